// File: rtl/ioctl_mem_arb_if.sv
// Bus bundle between hps_io ioctl writer, the core CPU and the shared memory controller.
// The arbiter takes the slave view; the surrounding system drives the master view.
interface ioctl_mem_arb_if #(
    parameter int AW = 25,
    parameter int DW = 8
) ();
    logic          ioctl_wr;
    logic [AW-1:0] ioctl_addr;
    logic [DW-1:0] ioctl_dout;
    logic          ioctl_wait;
    logic          ovf_err;

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_din;
    logic          cpu_busy;
    logic          cpu_ready;
    logic [DW-1:0] cpu_dout;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          mem_ack;
    logic [DW-1:0] mem_dout;

    modport slave (
        input  ioctl_wr, ioctl_addr, ioctl_dout,
        output ioctl_wait, ovf_err,
        input  cpu_req, cpu_we, cpu_addr, cpu_din,
        output cpu_busy, cpu_ready, cpu_dout,
        output mem_req, mem_we, mem_addr, mem_din,
        input  mem_ack, mem_dout
    );

    modport master (
        output ioctl_wr, ioctl_addr, ioctl_dout,
        input  ioctl_wait, ovf_err,
        output cpu_req, cpu_we, cpu_addr, cpu_din,
        input  cpu_busy, cpu_ready, cpu_dout,
        input  mem_req, mem_we, mem_addr, mem_din,
        output mem_ack, mem_dout
    );
endinterface

// File: rtl/ioctl_mem_arb.sv
// Round-robin arbiter sharing one single-port memory between the ioctl write stream and the CPU.
// Each side owns a one-entry buffer; every grant runs one req/ack transaction to memory.
module ioctl_mem_arb #(
    parameter int AW = 25,
    parameter int DW = 8
) (
    input  logic            clk_sys,
    input  logic            reset,
    ioctl_mem_arb_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_IO_XFER  = 2'd1,
        ST_CPU_XFER = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_IO  = 1'b0,
        GRANT_CPU = 1'b1
    } grant_t;

    state_t        state_q, state_d;
    grant_t        last_grant_q, last_grant_d;

    logic          io_v_q, io_v_d;
    logic [AW-1:0] io_addr_q, io_addr_d;
    logic [DW-1:0] io_data_q, io_data_d;
    logic          ioctl_wait_q, ioctl_wait_d;
    logic          ovf_q, ovf_d;

    logic          cpu_v_q, cpu_v_d;
    logic          cpu_we_q, cpu_we_d;
    logic [AW-1:0] cpu_addr_q, cpu_addr_d;
    logic [DW-1:0] cpu_data_q, cpu_data_d;
    logic          cpu_ready_q, cpu_ready_d;
    logic [DW-1:0] cpu_dout_q, cpu_dout_d;

    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_din_q, mem_din_d;

    logic          grant_io;
    logic          grant_cpu;

    // On a tie the side that did not win last time takes the memory.
    assign grant_io  = io_v_q && (!cpu_v_q || (last_grant_q == GRANT_CPU));
    assign grant_cpu = cpu_v_q && !grant_io;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        io_v_d       = io_v_q;
        io_addr_d    = io_addr_q;
        io_data_d    = io_data_q;
        ovf_d        = ovf_q;
        cpu_v_d      = cpu_v_q;
        cpu_we_d     = cpu_we_q;
        cpu_addr_d   = cpu_addr_q;
        cpu_data_d   = cpu_data_q;
        cpu_ready_d  = 1'b0;
        cpu_dout_d   = cpu_dout_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;

        if (bus.ioctl_wr) begin
            if (!io_v_q) begin
                io_v_d    = 1'b1;
                io_addr_d = bus.ioctl_addr;
                io_data_d = bus.ioctl_dout;
            end else begin
                ovf_d = 1'b1;
            end
        end

        // A CPU strobe against a full buffer is silently ignored.
        if (bus.cpu_req && !cpu_v_q) begin
            cpu_v_d    = 1'b1;
            cpu_we_d   = bus.cpu_we;
            cpu_addr_d = bus.cpu_addr;
            cpu_data_d = bus.cpu_din;
        end

        case (state_q)
            ST_IDLE: begin
                if (grant_io) begin
                    state_d      = ST_IO_XFER;
                    last_grant_d = GRANT_IO;
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b1;
                    mem_addr_d   = io_addr_q;
                    mem_din_d    = io_data_q;
                end else if (grant_cpu) begin
                    state_d      = ST_CPU_XFER;
                    last_grant_d = GRANT_CPU;
                    mem_req_d    = 1'b1;
                    mem_we_d     = cpu_we_q;
                    mem_addr_d   = cpu_addr_q;
                    mem_din_d    = cpu_data_q;
                end
            end
            ST_IO_XFER: begin
                if (bus.mem_ack) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    io_v_d    = 1'b0;
                end
            end
            ST_CPU_XFER: begin
                if (bus.mem_ack) begin
                    state_d     = ST_IDLE;
                    mem_req_d   = 1'b0;
                    cpu_v_d     = 1'b0;
                    cpu_ready_d = 1'b1;
                    if (!cpu_we_q) begin
                        cpu_dout_d = bus.mem_dout;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        ioctl_wait_d = io_v_d;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_CPU;
            io_v_q       <= 1'b0;
            io_addr_q    <= '0;
            io_data_q    <= '0;
            ioctl_wait_q <= 1'b0;
            ovf_q        <= 1'b0;
            cpu_v_q      <= 1'b0;
            cpu_we_q     <= 1'b0;
            cpu_addr_q   <= '0;
            cpu_data_q   <= '0;
            cpu_ready_q  <= 1'b0;
            cpu_dout_q   <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            io_v_q       <= io_v_d;
            io_addr_q    <= io_addr_d;
            io_data_q    <= io_data_d;
            ioctl_wait_q <= ioctl_wait_d;
            ovf_q        <= ovf_d;
            cpu_v_q      <= cpu_v_d;
            cpu_we_q     <= cpu_we_d;
            cpu_addr_q   <= cpu_addr_d;
            cpu_data_q   <= cpu_data_d;
            cpu_ready_q  <= cpu_ready_d;
            cpu_dout_q   <= cpu_dout_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
        end
    end

    assign bus.ioctl_wait = ioctl_wait_q;
    assign bus.ovf_err    = ovf_q;
    assign bus.cpu_busy   = cpu_v_q;
    assign bus.cpu_ready  = cpu_ready_q;
    assign bus.cpu_dout   = cpu_dout_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_din    = mem_din_q;
endmodule
